// File: rtl/sequential_multiplier.sv
// Bit-serial shift-add multiplier: scaled_count (8b) x multiplier (24b) -> 24-bit saturated count.
// One multiplicand bit is consumed per TEST/[ADD]/SHIFT/CHECK_CNT pass, so a single 32-bit adder suffices.
module sequential_multiplier (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        sample_now,
    input  logic [7:0]  scaled_count,
    input  logic [23:0] multiplier,
    output logic [23:0] count,
    output logic        overflow,
    output logic        done,
    output logic        busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TEST      = 3'd1;
    localparam logic [2:0] S_ADD       = 3'd2;
    localparam logic [2:0] S_SHIFT     = 3'd3;
    localparam logic [2:0] S_CHECK_CNT = 3'd4;

    logic [2:0]  state;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [7:0]  mbits;
    logic [2:0]  n;

    // Clamp the 32-bit accumulator to the 24-bit result range.
    function automatic logic [23:0] sat24(input logic [31:0] a);
        return (a[31:24] == 8'd0) ? a[23:0] : 24'hFFFFFF;
    endfunction

    function automatic logic ovf24(input logic [31:0] a);
        return |a[31:24];
    endfunction

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= S_IDLE;
            acc      <= 32'd0;
            mcand    <= 32'd0;
            mbits    <= 8'd0;
            n        <= 3'd0;
            count    <= 24'd0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sample_now) begin
                        acc   <= 32'd0;
                        mcand <= {8'd0, multiplier};
                        mbits <= scaled_count;
                        n     <= 3'd0;
                        state <= S_TEST;
                    end
                end
                S_TEST: begin
                    state <= mbits[0] ? S_ADD : S_SHIFT;
                end
                S_ADD: begin
                    // 8x24 product fits in 32 bits, so no carry-out is lost here.
                    acc   <= acc + mcand;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    mcand <= mcand << 1;
                    mbits <= mbits >> 1;
                    state <= S_CHECK_CNT;
                end
                S_CHECK_CNT: begin
                    if (n == 3'd7) begin
                        n        <= 3'd0;
                        state    <= S_IDLE;
                        count    <= sat24(acc);
                        overflow <= ovf24(acc);
                        done     <= 1'b1;
                    end else begin
                        n     <= n + 3'd1;
                        state <= S_TEST;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_multiplier.sv
// Directed bench for sequential_multiplier with a queue scoreboard checked on every done pulse.
module tb_sequential_multiplier;

    logic        clk;
    logic        n_rst;
    logic        sample_now;
    logic [7:0]  scaled_count;
    logic [23:0] multiplier;
    logic [23:0] count;
    logic        overflow;
    logic        done;
    logic        busy;

    sequential_multiplier dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .sample_now   (sample_now),
        .scaled_count (scaled_count),
        .multiplier   (multiplier),
        .count        (count),
        .overflow     (overflow),
        .done         (done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] cnt;
        logic        ovf;
        int          done_edge;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [7:0] sc, input logic [23:0] m, input int acc_edge);
        exp_t e;
        logic [31:0] p;
        p = {24'd0, sc} * {8'd0, m};
        e.cnt = (p[31:24] == 8'd0) ? p[23:0] : 24'hFFFFFF;
        e.ovf = |p[31:24];
        e.done_edge = acc_edge + 24 + $countones(sc);
        return e;
    endfunction

    // Every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (n_rst === 1'b1 && done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("count", {8'd0, count}, {8'd0, e.cnt});
                chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                chk("done_edge", edge_cnt, e.done_edge);
                chk("busy_in_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic start_op(input logic [7:0] sc, input logic [23:0] m);
        @(negedge clk);
        scaled_count = sc;
        multiplier   = m;
        sample_now   = 1'b1;
        q.push_back(model(sc, m, edge_cnt + 1));
        @(negedge clk);
        sample_now = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk("drain_timeout", q.size(), 32'd0);
    endtask

    task automatic wait_until(input int target);
        while (edge_cnt < target) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=finish", edge_cnt);
        $fatal(1, "timeout");
    end

    initial begin
        int a;
        n_rst        = 1'b1;
        sample_now   = 1'b0;
        scaled_count = 8'd0;
        multiplier   = 24'd0;

        // Asynchronous reset mid-cycle
        #13 n_rst = 1'b0;
        #1;
        chk("rst_count", {8'd0, count}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        start_op(8'h80, 24'd1000);
        wait_drain(40);
        chk("idle_after_op1", {31'd0, busy}, 32'd0);

        start_op(8'hFF, 24'h010000);
        wait_drain(40);

        start_op(8'hFF, 24'hFFFFFF);
        wait_drain(40);

        start_op(8'h00, 24'h123456);
        a = edge_cnt;
        // Input changes and a request while busy must be ignored
        wait_until(a + 4);
        scaled_count = 8'hAA;
        multiplier   = 24'h000777;
        sample_now   = 1'b1;
        @(negedge clk);
        sample_now   = 1'b0;
        scaled_count = 8'hFF;
        multiplier   = 24'hFFFFFF;
        // Hold sample_now high across the done cycle: restart with no idle gap
        wait_until(a + 23);
        scaled_count = 8'h03;
        multiplier   = 24'd10;
        sample_now   = 1'b1;
        q.push_back(model(8'h03, 24'd10, a + 25));
        wait_until(a + 51);
        scaled_count = 8'h05;
        multiplier   = 24'd3;
        q.push_back(model(8'h05, 24'd3, a + 52));
        @(negedge clk);
        sample_now = 1'b0;
        wait_drain(40);

        // Reset mid-operation aborts with no done and clears count
        start_op(8'h0F, 24'd7);
        a = edge_cnt;
        wait_until(a + 9);
        #2 n_rst = 1'b0;
        q.delete();
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_count", {8'd0, count}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_count", {8'd0, count}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        start_op(8'h0F, 24'd7);
        wait_drain(40);
        chk("final_count", {8'd0, count}, 32'd105);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequential_multiplier.md
# sequential_multiplier

Bit-serial shift-add multiplier that scales an 8-bit scaled count back up to a 24-bit count by computing `scaled_count × multiplier`, the inverse of the 24-bit-to-8-bit sequential divide. It is used wherever an 8-bit synth parameter must be turned back into a full-width period or step count. It processes one multiplier bit per 3–4 cycles, so the datapath stays at one 32-bit adder and meets Tiny Tapeout timing. The result saturates to 24 bits and raises an overflow flag.

## Interface
- No parameters. Widths are fixed: 8-bit scaled count, 24-bit multiplier, 32-bit internal accumulator, 24-bit result.
- `clk`  in  1  system clock; all state updates on rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `sample_now`  in  1  start request; accepted only in IDLE.
- `scaled_count`  in  8  multiplicand bits, processed LSB first.
- `multiplier`  in  24  scale factor.
- `count`  out  24  latched saturated product; holds until the next completion.
- `overflow`  out  1  high when the latched product exceeded 24'hFFFFFF; updates together with `count`.
- `done`  out  1  registered one-cycle pulse; `count` and `overflow` are new in the same cycle.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Registers:
  - `acc[31:0]`: accumulator.
  - `mcand[31:0]`: shifted multiplier.
  - `mbits[7:0]`: remaining scaled-count bits.
  - `n[2:0]`: bit counter.
  - `state`.
  - Output registers: `count`, `overflow`, `done`.
- States: IDLE, TEST, ADD, SHIFT, CHECK_CNT.
- **IDLE**: when `sample_now` is high, load `acc=0`, `mcand={8'b0,multiplier}`, `mbits=scaled_count`, `n=0`, then go to TEST. Otherwise stay in IDLE.
- **TEST**: if `mbits[0]`, go to ADD; otherwise go to SHIFT.
- **ADD**: `acc = acc + mcand` (32-bit, no carry-out possible), then go to SHIFT.
- **SHIFT**: `mcand = mcand << 1`, `mbits = mbits >> 1`, then go to CHECK_CNT.
- **CHECK_CNT**:
  - If `n==7`: go to IDLE, `n=0`, and at the same edge:
    - `count = (acc[31:24]==0) ? acc[23:0] : 24'hFFFFFF`
    - `overflow = |acc[31:24]`
    - `done = 1`
  - Otherwise: `n = n+1`, go to TEST.
- `done` is cleared at every other edge, so it is exactly one cycle wide.
- The sequence always runs all 8 iterations. There is no early exit for a zero operand; a zero operand gives `count=0`, `overflow=0`.
- Inputs are sampled only at the accepting edge. Changes to inputs while `busy` have no effect.
- `sample_now` while `busy` is ignored, not queued.
- Unused state encodings go to IDLE with no other register change.

## Timing
- Reset values:
  - All outputs: `count=0`, `overflow=0`, `done=0`, `busy=0`.
  - Internal: `state=IDLE`, `acc`, `mcand`, `mbits`, `n` all 0.
- Reset mid-operation aborts the operation immediately. The previous `count` is lost (cleared to 0) and no `done` is produced.
- Latency: let `sample_now` be accepted at edge E0, and let k = popcount(`scaled_count`).
  - `done`, the new `count` and `overflow` become visible after edge E(24+k).
  - `busy` is high from E0 through E(24+k); it is low in the `done` cycle.
  - Minimum latency is 24 cycles; maximum is 32.
- Back-to-back operation: in the `done` cycle the state is IDLE. If `sample_now` is high there, it is accepted at the next edge, so the restart gap is 0 idle cycles.
- `sample_now` held high continuously gives one operation per 25+k cycles, each using the inputs present at its accepting edge.

## Test plan
- **Reset**: assert `n_rst=0` asynchronously mid-cycle → `count=0`, `overflow=0`, `done=0`, `busy=0` immediately, with no clock edge needed.
- **Single set bit**: `scaled_count=8'h80`, `multiplier=24'd1000`, one-cycle `sample_now` at E0 → `done` after E25 only, `count=24'd128000`, `overflow=0`, `busy` low after E25.
- **All bits set, no overflow**: `scaled_count=8'hFF`, `multiplier=24'h010000` → `done` after E32, `count=24'hFF0000`, `overflow=0`.
- **Saturation**: `scaled_count=8'hFF`, `multiplier=24'hFFFFFF` → `done` after E32, `count=24'hFFFFFF`, `overflow=1`.
- **Input hold and restart**:
  - Start with `scaled_count=8'h00`, `multiplier=24'h123456`.
  - Change both inputs while busy, and pulse `sample_now` at E5.
  - Required: `done` after E24 with `count=0`; the E5 request is ignored.
  - Then hold `sample_now` high with `scaled_count=8'h03`, `multiplier=24'd10` → the next `done` follows 26 edges later with `count=24'd30`.
- **Reset mid-operation**: start `8'h0F` × `24'd7` (product 24'd105), then pulse `n_rst` low at cycle 10 → `busy` drops at once, no `done` ever appears, `count=0`. A fresh start afterwards completes normally with `count=24'd105`.
